// File: rtl/div_pipe_param_pkg.sv
// Shared divider constants, stage record and stage-count helper.
package div_pipe_param_pkg;

   localparam int DIV_N_BITS = 32;
   localparam int DIV_BPS    = 4;
   localparam int DIV_TAG_W  = 4;

   function automatic int div_stages(input int n_bits, input int bps);
      return n_bits / bps;
   endfunction

   localparam int DIV_LAT = div_stages(DIV_N_BITS, DIV_BPS) + 2;

   typedef struct packed {
      logic                   valid;
      logic [DIV_N_BITS:0]    rem;
      logic [DIV_N_BITS-1:0]  quo;
      logic [DIV_N_BITS-1:0]  divisor;
      logic                   qsign;
      logic                   rsign;
      logic                   dbz;
      logic [DIV_N_BITS-1:0]  a_orig;
      logic [DIV_TAG_W-1:0]   tag;
   } div_stage_t;

endpackage

// File: rtl/div_iter_stage.sv
// One iteration stage: BITS_PER_STAGE chained restoring steps plus its pipeline register.
module div_iter_stage
   import div_pipe_param_pkg::*;
#(
   parameter int N_BITS         = 32,
   parameter int BITS_PER_STAGE = 4,
   parameter int SIDE_W         = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   input  logic                adv_i,
   input  logic                valid_i,
   input  logic [N_BITS:0]     rem_i,
   input  logic [N_BITS-1:0]   quo_i,
   input  logic [N_BITS-1:0]   div_i,
   input  logic [SIDE_W-1:0]   side_i,
   output logic                valid_o,
   output logic [N_BITS:0]     rem_o,
   output logic [N_BITS-1:0]   quo_o,
   output logic [N_BITS-1:0]   div_o,
   output logic [SIDE_W-1:0]   side_o
);

   logic                valid_q;
   logic [N_BITS:0]     rem_q, rem_d;
   logic [N_BITS-1:0]   quo_q, quo_d, div_q;
   logic [SIDE_W-1:0]   side_q;
   logic                unused_s;

   // The partial remainder stays below the divisor, so its carry bit is never shifted out.
   assign unused_s = rem_i[N_BITS];

   // quo carries the not-yet-consumed dividend bits in its top and collects quotient bits at the bottom
   always_comb begin
      rem_d = rem_i;
      quo_d = quo_i;
      for (int k = 0; k < BITS_PER_STAGE; k++) begin
         rem_d = {rem_d[N_BITS-1:0], quo_d[N_BITS-1]};
         quo_d = {quo_d[N_BITS-2:0], 1'b0};
         if (rem_d >= {1'b0, div_i}) begin
            rem_d    = rem_d - {1'b0, div_i};
            quo_d[0] = 1'b1;
         end else begin
            quo_d[0] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         valid_q <= 1'b0;
      end else if (adv_i) begin
         valid_q <= valid_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (adv_i) begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         div_q  <= div_i;
         side_q <= side_i;
      end
   end

   assign valid_o = valid_q;
   assign rem_o   = rem_q;
   assign quo_o   = quo_q;
   assign div_o   = div_q;
   assign side_o  = side_q;

endmodule

// File: rtl/div_pipe_param.sv
// Fully pipelined signed/unsigned divider: pre-stage, S iteration stages, sign-fixup stage.
module div_pipe_param
   import div_pipe_param_pkg::*;
#(
   parameter int N_BITS         = 32,
   parameter int BITS_PER_STAGE = 4,
   parameter int TAG_W          = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [N_BITS-1:0]   a_i,
   input  logic [N_BITS-1:0]   b_i,
   input  logic                signed_i,
   input  logic [TAG_W-1:0]    tag_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [N_BITS-1:0]   q_o,
   output logic [N_BITS-1:0]   r_o,
   output logic [TAG_W-1:0]    tag_o,
   output logic                dbz_o,
   output logic                busy_o
);

   localparam int S      = div_stages(N_BITS, BITS_PER_STAGE);
   localparam int SIDE_W = 3 + N_BITS + TAG_W;

   logic                      adv_s;
   logic                      a_neg_s, b_neg_s;
   logic                      p_valid_q;
   logic [N_BITS-1:0]         p_quo_q, p_div_q;
   logic [SIDE_W-1:0]         p_side_q;

   logic [S:0]                valid_s;
   logic [S:0][N_BITS:0]      rem_s;
   logic [S:0][N_BITS-1:0]    quo_s, div_s;
   logic [S:0][SIDE_W-1:0]    side_s;

   logic                      f_qsign_s, f_rsign_s, f_dbz_s;
   logic [N_BITS-1:0]         f_aorig_s;
   logic [TAG_W-1:0]          f_tag_s;
   logic [N_BITS-1:0]         q_d, r_d;
   logic                      out_valid_q, dbz_q;
   logic [N_BITS-1:0]         q_q, r_q;
   logic [TAG_W-1:0]          tag_q;
   logic                      unused_s;

   // A single advance strobe moves the whole pipe; bubbles travel with it.
   assign adv_s      = out_ready_i | ~out_valid_q;
   assign in_ready_o = adv_s;
   assign a_neg_s    = signed_i & a_i[N_BITS-1];
   assign b_neg_s    = signed_i & b_i[N_BITS-1];

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         p_valid_q <= 1'b0;
      end else if (adv_s) begin
         p_valid_q <= in_valid_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (adv_s) begin
         p_quo_q  <= a_neg_s ? -a_i : a_i;
         p_div_q  <= b_neg_s ? -b_i : b_i;
         p_side_q <= {a_neg_s ^ b_neg_s, a_neg_s, (b_i == '0), a_i, tag_i};
      end
   end

   assign valid_s[0] = p_valid_q;
   assign rem_s[0]   = '0;
   assign quo_s[0]   = p_quo_q;
   assign div_s[0]   = p_div_q;
   assign side_s[0]  = p_side_q;

   for (genvar g = 0; g < S; g++) begin : g_iter
      div_iter_stage #(
         .N_BITS         (N_BITS),
         .BITS_PER_STAGE (BITS_PER_STAGE),
         .SIDE_W         (SIDE_W)
      ) u_stage (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .flush_i (flush_i),
         .adv_i   (adv_s),
         .valid_i (valid_s[g]),
         .rem_i   (rem_s[g]),
         .quo_i   (quo_s[g]),
         .div_i   (div_s[g]),
         .side_i  (side_s[g]),
         .valid_o (valid_s[g+1]),
         .rem_o   (rem_s[g+1]),
         .quo_o   (quo_s[g+1]),
         .div_o   (div_s[g+1]),
         .side_o  (side_s[g+1])
      );
   end

   assign {f_qsign_s, f_rsign_s, f_dbz_s, f_aorig_s, f_tag_s} = side_s[S];
   assign unused_s = ^{rem_s[S][N_BITS], div_s[S]};

   // MIN / -1 lands here as |q| = MIN with qsign = 0, which is already the wrapped result
   always_comb begin
      q_d = quo_s[S];
      r_d = rem_s[S][N_BITS-1:0];
      if (f_dbz_s) begin
         q_d = '1;
         r_d = f_aorig_s;
      end else begin
         q_d = f_qsign_s ? -quo_s[S] : quo_s[S];
         r_d = f_rsign_s ? -rem_s[S][N_BITS-1:0] : rem_s[S][N_BITS-1:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_q <= 1'b0;
         q_q         <= '0;
         r_q         <= '0;
         tag_q       <= '0;
         dbz_q       <= 1'b0;
      end else begin
         if (flush_i) begin
            out_valid_q <= 1'b0;
         end else if (adv_s) begin
            out_valid_q <= valid_s[S];
         end
         if (adv_s) begin
            q_q   <= q_d;
            r_q   <= r_d;
            tag_q <= f_tag_s;
            dbz_q <= f_dbz_s;
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign q_o         = q_q;
   assign r_o         = r_q;
   assign tag_o       = tag_q;
   assign dbz_o       = dbz_q;
   assign busy_o      = (|valid_s) | out_valid_q;

endmodule
